// File: rtl/fork_join_pkg.sv
// Shared types and helpers for the fork/join sequencer.
// Pure declarations: no logic and no state.
package fork_join_pkg;

    typedef enum logic [1:0] {
        JOIN_ALL  = 2'd0,
        JOIN_ANY  = 2'd1,
        JOIN_NONE = 2'd2
    } join_mode_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FORK  = 2'd1,
        POST  = 2'd2,
        DRAIN = 2'd3
    } fj_state_e;

    // Widest counter the helper supports; callers size-cast in and out.
    localparam int FJ_MAX_W = 32;
    typedef logic [FJ_MAX_W-1:0] fj_wide_t;

    // A zero delay still costs one cycle.
    function automatic fj_wide_t eff_delay(input fj_wide_t d);
        return (d == '0) ? fj_wide_t'(1) : d;
    endfunction

    // The reserved encoding behaves as JOIN_ALL.
    function automatic join_mode_e decode_mode(input logic [1:0] m);
        case (m)
            2'd1:    return JOIN_ANY;
            2'd2:    return JOIN_NONE;
            default: return JOIN_ALL;
        endcase
    endfunction

endpackage

// File: rtl/fork_join_ctrl_if.sv
// Control and status bundle for fork_join_ctrl.
// Plain level/pulse signals: no handshake, and the controller never stalls.
interface fork_join_ctrl_if #(
    parameter int N_CH  = 2,
    parameter int CNT_W = 16
);
    logic                  start;
    logic                  abort;
    logic [1:0]            mode;
    logic [N_CH-1:0]       ch_en;
    logic [N_CH*CNT_W-1:0] ch_delay;
    logic [CNT_W-1:0]      post_delay;

    logic                  busy;
    logic [N_CH-1:0]       ch_active;
    logic [N_CH-1:0]       ch_done;
    logic                  join_pulse;
    logic                  post_done;
    logic                  start_ignored;
    logic [CNT_W-1:0]      elapsed;

    modport master (
        output start, abort, mode, ch_en, ch_delay, post_delay,
        input  busy, ch_active, ch_done, join_pulse, post_done, start_ignored, elapsed
    );

    modport slave (
        input  start, abort, mode, ch_en, ch_delay, post_delay,
        output busy, ch_active, ch_done, join_pulse, post_done, start_ignored, elapsed
    );
endinterface

// File: rtl/fj_timer.sv
// Loadable down-counter. done pulses in the cycle after edge load+load_val.
// Latency: exactly load_val edges (load_val >= 1). Clear wins over load and suppresses expiry.
module fj_timer #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             clear,
    output logic             active,
    output logic             expiring,
    output logic             done
);
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             active_q, active_d;
    logic             done_q, done_d;

    // High during the cycle whose closing edge ends the count.
    assign expiring = active_q && (cnt_q == CNT_W'(1)) && !clear && !load;

    always_comb begin
        cnt_d    = cnt_q;
        active_d = active_q;
        done_d   = 1'b0;
        if (clear) begin
            cnt_d    = '0;
            active_d = 1'b0;
        end else if (load) begin
            cnt_d    = load_val;
            active_d = 1'b1;
        end else if (active_q) begin
            if (cnt_q == CNT_W'(1)) begin
                cnt_d    = '0;
                active_d = 1'b0;
                done_d   = 1'b1;
            end else begin
                cnt_d = cnt_q - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q    <= '0;
            active_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            active_q <= active_d;
            done_q   <= done_d;
        end
    end

    assign active = active_q;
    assign done   = done_q;
endmodule

// File: rtl/fork_join_ctrl.sv
// Fork/join sequencer: N_CH channel timers, join detection, one post timer, elapsed count.
// Latency: pulses appear the cycle after their edge. No backpressure; start while busy is dropped and flagged.
module fork_join_ctrl #(
    parameter int N_CH  = 2,
    parameter int CNT_W = 16
) (
    input  logic clk,
    input  logic rst_n,
    fork_join_ctrl_if.slave bus
);
    import fork_join_pkg::*;

    fj_state_e        state_q, state_d;
    join_mode_e       mode_q, mode_d;
    logic [N_CH-1:0]  ch_en_q, ch_en_d;
    logic [CNT_W-1:0] post_delay_q, post_delay_d;
    logic [CNT_W-1:0] elapsed_q, elapsed_d;
    logic             busy_q, busy_d;
    logic             join_pulse_q, join_pulse_d;
    logic             start_ignored_q, start_ignored_d;

    logic [N_CH-1:0]  ch_active, ch_exp, ch_done;
    logic             post_active, post_exp, post_done;
    logic [CNT_W-1:0] post_load_val;
    logic             start_acc, clear_all, join_cond, join_now, ch_left;

    assign start_acc = bus.start && !bus.abort && (state_q == IDLE);
    assign clear_all = bus.abort && (state_q != IDLE);

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        logic [CNT_W-1:0] load_val;
        assign load_val = CNT_W'(eff_delay(FJ_MAX_W'(bus.ch_delay[i*CNT_W +: CNT_W])));

        fj_timer #(.CNT_W(CNT_W)) u_timer (
            .clk      (clk),
            .rst_n    (rst_n),
            .load     (start_acc && bus.ch_en[i]),
            .load_val (load_val),
            .clear    (clear_all),
            .active   (ch_active[i]),
            .expiring (ch_exp[i]),
            .done     (ch_done[i])
        );
    end

    assign post_load_val = CNT_W'(eff_delay(FJ_MAX_W'(post_delay_q)));

    fj_timer #(.CNT_W(CNT_W)) u_post (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (join_now),
        .load_val (post_load_val),
        .clear    (clear_all),
        .active   (post_active),
        .expiring (post_exp),
        .done     (post_done)
    );

    // Join is judged on what the channels will look like after the coming edge.
    always_comb begin
        ch_left = |(ch_active & ~ch_exp);
        case (mode_q)
            JOIN_ANY:  join_cond = |(ch_en_q & ch_exp);
            JOIN_NONE: join_cond = 1'b1;
            default:   join_cond = !ch_left;
        endcase
        if (ch_en_q == '0) begin
            join_cond = 1'b1;
        end
        join_now = (state_q == FORK) && !bus.abort && join_cond;
    end

    always_comb begin
        state_d         = state_q;
        mode_d          = mode_q;
        ch_en_d         = ch_en_q;
        post_delay_d    = post_delay_q;
        elapsed_d       = elapsed_q;
        join_pulse_d    = join_now;
        start_ignored_d = bus.start && (state_q != IDLE);

        case (state_q)
            IDLE: begin
                if (start_acc) begin
                    state_d      = FORK;
                    mode_d       = decode_mode(bus.mode);
                    ch_en_d      = bus.ch_en;
                    post_delay_d = bus.post_delay;
                    elapsed_d    = '0;
                end
            end
            FORK: begin
                if (join_now) begin
                    state_d = POST;
                end
            end
            POST: begin
                if (post_exp || !post_active) begin
                    state_d = ch_left ? DRAIN : IDLE;
                end
            end
            DRAIN: begin
                if (!ch_left) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Abort freezes elapsed at its current value, same as a normal run end.
        if (state_q != IDLE) begin
            if (bus.abort) begin
                state_d = IDLE;
            end else if (elapsed_q != '1) begin
                elapsed_d = elapsed_q + CNT_W'(1);
            end
        end

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= IDLE;
            mode_q          <= JOIN_ALL;
            ch_en_q         <= '0;
            post_delay_q    <= '0;
            elapsed_q       <= '0;
            busy_q          <= 1'b0;
            join_pulse_q    <= 1'b0;
            start_ignored_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            mode_q          <= mode_d;
            ch_en_q         <= ch_en_d;
            post_delay_q    <= post_delay_d;
            elapsed_q       <= elapsed_d;
            busy_q          <= busy_d;
            join_pulse_q    <= join_pulse_d;
            start_ignored_q <= start_ignored_d;
        end
    end

    assign bus.busy          = busy_q;
    assign bus.ch_active     = ch_active;
    assign bus.ch_done       = ch_done;
    assign bus.join_pulse    = join_pulse_q;
    assign bus.post_done     = post_done;
    assign bus.start_ignored = start_ignored_q;
    assign bus.elapsed       = elapsed_q;
endmodule

// File: tb/tb_fork_join_ctrl.sv
// Directed bench for fork_join_ctrl with N_CH=2, CNT_W=16.
// Event times are counted in edges after the edge that accepts start.
module tb_fork_join_ctrl;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    fork_join_ctrl_if #(.N_CH(2), .CNT_W(16)) bus ();

    fork_join_ctrl #(.N_CH(2), .CNT_W(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_chk = 0;
    int n_pass = 0;
    int t_d0, t_d1, t_join, t_post, t_idle, t_ign;
    int n_d0, n_d1, n_join, n_post, n_ign;
    logic [15:0] el_end;

    task automatic clear_rec();
        t_d0 = -1; t_d1 = -1; t_join = -1; t_post = -1; t_idle = -1; t_ign = -1;
        n_d0 = 0; n_d1 = 0; n_join = 0; n_post = 0; n_ign = 0;
        el_end = '0;
    endtask

    // Presents a start for one edge (E0); returns #1 after E0.
    task automatic launch(input logic [1:0] m, input logic [1:0] en,
                          input logic [15:0] d0, input logic [15:0] d1, input logic [15:0] p);
        clear_rec();
        bus.mode       = m;
        bus.ch_en      = en;
        bus.ch_delay   = {d1, d0};
        bus.post_delay = p;
        bus.start      = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
    endtask

    // Runs ncyc edges, optionally pulsing start/abort so they are sampled at a given edge.
    task automatic watch(input int ncyc, input int restart_at, input int abort_at);
        for (int k = 1; k <= ncyc; k++) begin
            bus.start = (k == restart_at);
            bus.abort = (k == abort_at);
            @(posedge clk);
            #1;
            bus.start = 1'b0;
            bus.abort = 1'b0;
            if (bus.ch_done[0]) begin n_d0++; if (t_d0 < 0) t_d0 = k; end
            if (bus.ch_done[1]) begin n_d1++; if (t_d1 < 0) t_d1 = k; end
            if (bus.join_pulse) begin n_join++; if (t_join < 0) t_join = k; end
            if (bus.post_done) begin n_post++; if (t_post < 0) t_post = k; end
            if (bus.start_ignored) begin n_ign++; if (t_ign < 0) t_ign = k; end
            if (!bus.busy && t_idle < 0) t_idle = k;
            el_end = bus.elapsed;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_chk++; if ({bus.busy, bus.join_pulse, bus.post_done, bus.start_ignored} !== 4'b0) $display("FAIL reset_flags got %b want 0000", {bus.busy, bus.join_pulse, bus.post_done, bus.start_ignored}); else n_pass++;
        n_chk++; if ({bus.ch_active, bus.ch_done} !== 4'b0) $display("FAIL reset_ch got %b want 0000", {bus.ch_active, bus.ch_done}); else n_pass++;
        n_chk++; if (bus.elapsed !== 16'd0) $display("FAIL reset_elapsed got %0d want 0", bus.elapsed); else n_pass++;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_join_all(input logic [1:0] m, input string nm);
        launch(m, 2'b11, 16'd10, 16'd20, 16'd5);
        n_chk++; if (bus.busy !== 1'b1 || bus.elapsed !== 16'd0) $display("FAIL %s_start busy=%b elapsed=%0d want 1/0", nm, bus.busy, bus.elapsed); else n_pass++;
        n_chk++; if (bus.ch_active !== 2'b11) $display("FAIL %s_active got %b want 11", nm, bus.ch_active); else n_pass++;
        watch(35, 0, 0);
        n_chk++; if (t_d0 !== 10 || t_d1 !== 20) $display("FAIL %s_done got %0d/%0d want 10/20", nm, t_d0, t_d1); else n_pass++;
        n_chk++; if (t_join !== 20 || n_join !== 1) $display("FAIL %s_join got t=%0d n=%0d want 20/1", nm, t_join, n_join); else n_pass++;
        n_chk++; if (t_post !== 25) $display("FAIL %s_post got %0d want 25", nm, t_post); else n_pass++;
        n_chk++; if (t_idle !== 25) $display("FAIL %s_idle got %0d want 25", nm, t_idle); else n_pass++;
        n_chk++; if (el_end !== 16'd25) $display("FAIL %s_elapsed got %0d want 25", nm, el_end); else n_pass++;
    endtask

    task automatic test_join_any();
        launch(2'd1, 2'b11, 16'd10, 16'd20, 16'd5);
        watch(30, 0, 0);
        n_chk++; if (t_join !== 10 || n_join !== 1) $display("FAIL any_join got t=%0d n=%0d want 10/1", t_join, n_join); else n_pass++;
        n_chk++; if (t_post !== 15) $display("FAIL any_post got %0d want 15", t_post); else n_pass++;
        n_chk++; if (t_d1 !== 20 || t_idle !== 20) $display("FAIL any_drain got d1=%0d idle=%0d want 20/20", t_d1, t_idle); else n_pass++;
        n_chk++; if (el_end !== 16'd20) $display("FAIL any_elapsed got %0d want 20", el_end); else n_pass++;
    endtask

    task automatic test_join_none();
        launch(2'd2, 2'b11, 16'd10, 16'd20, 16'd5);
        watch(30, 0, 0);
        n_chk++; if (t_join !== 1) $display("FAIL none_join got %0d want 1", t_join); else n_pass++;
        n_chk++; if (t_post !== 6) $display("FAIL none_post got %0d want 6", t_post); else n_pass++;
        n_chk++; if (t_d0 !== 10 || t_d1 !== 20) $display("FAIL none_done got %0d/%0d want 10/20", t_d0, t_d1); else n_pass++;
        n_chk++; if (t_idle !== 20) $display("FAIL none_idle got %0d want 20", t_idle); else n_pass++;
    endtask

    task automatic test_simultaneous();
        launch(2'd1, 2'b11, 16'd7, 16'd7, 16'd2);
        watch(20, 0, 0);
        n_chk++; if (t_d0 !== 7 || t_d1 !== 7) $display("FAIL simul_done got %0d/%0d want 7/7", t_d0, t_d1); else n_pass++;
        n_chk++; if (n_join !== 1 || t_join !== 7) $display("FAIL simul_join got n=%0d t=%0d want 1/7", n_join, t_join); else n_pass++;
        n_chk++; if (t_post !== 9 || t_idle !== 9) $display("FAIL simul_post got post=%0d idle=%0d want 9/9", t_post, t_idle); else n_pass++;
    endtask

    task automatic test_post_with_last();
        launch(2'd1, 2'b11, 16'd4, 16'd9, 16'd5);
        watch(20, 0, 0);
        n_chk++; if (t_join !== 4 || t_post !== 9 || t_d1 !== 9) $display("FAIL postlast_times got j=%0d p=%0d d1=%0d want 4/9/9", t_join, t_post, t_d1); else n_pass++;
        n_chk++; if (t_idle !== 9) $display("FAIL postlast_idle got %0d want 9", t_idle); else n_pass++;
    endtask

    task automatic test_zero_delay();
        launch(2'd0, 2'b11, 16'd0, 16'd0, 16'd0);
        watch(10, 0, 0);
        n_chk++; if (t_d0 !== 1 || t_d1 !== 1 || t_join !== 1) $display("FAIL zero_join got d=%0d/%0d j=%0d want 1/1/1", t_d0, t_d1, t_join); else n_pass++;
        n_chk++; if (t_post !== 2 || t_idle !== 2) $display("FAIL zero_post got post=%0d idle=%0d want 2/2", t_post, t_idle); else n_pass++;
    endtask

    task automatic test_start_ignored();
        launch(2'd0, 2'b11, 16'd10, 16'd20, 16'd5);
        bus.mode       = 2'd1;
        bus.ch_delay   = {16'd3, 16'd3};
        bus.post_delay = 16'd1;
        watch(35, 3, 0);
        n_chk++; if (t_ign !== 3 || n_ign !== 1) $display("FAIL ign_pulse got t=%0d n=%0d want 3/1", t_ign, n_ign); else n_pass++;
        n_chk++; if (t_d0 !== 10 || t_d1 !== 20 || t_join !== 20) $display("FAIL ign_times got d=%0d/%0d j=%0d want 10/20/20", t_d0, t_d1, t_join); else n_pass++;
        n_chk++; if (t_post !== 25 || t_idle !== 25) $display("FAIL ign_end got post=%0d idle=%0d want 25/25", t_post, t_idle); else n_pass++;
    endtask

    task automatic test_abort();
        launch(2'd0, 2'b11, 16'd10, 16'd20, 16'd5);
        watch(25, 0, 13);
        n_chk++; if (t_d0 !== 10 || t_idle !== 13) $display("FAIL abort_idle got d0=%0d idle=%0d want 10/13", t_d0, t_idle); else n_pass++;
        n_chk++; if (n_d1 !== 0 || n_join !== 0 || n_post !== 0) $display("FAIL abort_pulses got d1=%0d j=%0d p=%0d want 0/0/0", n_d1, n_join, n_post); else n_pass++;
        n_chk++; if (el_end !== 16'd12) $display("FAIL abort_elapsed got %0d want 12", el_end); else n_pass++;
        n_chk++; if (bus.ch_active !== 2'b00) $display("FAIL abort_active got %b want 00", bus.ch_active); else n_pass++;
    endtask

    task automatic test_start_abort_idle();
        clear_rec();
        bus.ch_en = 2'b11;
        bus.start = 1'b1;
        bus.abort = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.abort = 1'b0;
        n_chk++; if (bus.busy !== 1'b0 || bus.start_ignored !== 1'b0) $display("FAIL startabort got busy=%b ign=%b want 0/0", bus.busy, bus.start_ignored); else n_pass++;
        watch(5, 0, 0);
        n_chk++; if (t_idle !== 1 || n_d0 !== 0 || bus.elapsed !== 16'd12) $display("FAIL startabort_after got idle=%0d d0=%0d el=%0d want 1/0/12", t_idle, n_d0, bus.elapsed); else n_pass++;
    endtask

    task automatic test_reset_mid_run();
        launch(2'd0, 2'b11, 16'd10, 16'd20, 16'd5);
        watch(12, 0, 0);
        #1 rst_n = 1'b0;
        #1;
        n_chk++; if ({bus.busy, bus.ch_active, bus.ch_done, bus.join_pulse, bus.post_done} !== 7'b0) $display("FAIL rstmid_out got %b want 0", {bus.busy, bus.ch_active, bus.ch_done, bus.join_pulse, bus.post_done}); else n_pass++;
        n_chk++; if (bus.elapsed !== 16'd0) $display("FAIL rstmid_elapsed got %0d want 0", bus.elapsed); else n_pass++;
        #2 rst_n = 1'b1;
        clear_rec();
        watch(25, 0, 0);
        n_chk++; if (n_d0 + n_d1 + n_join + n_post !== 0) $display("FAIL rstmid_stale got %0d pulses want 0", n_d0 + n_d1 + n_join + n_post); else n_pass++;
    endtask

    task automatic test_no_channels();
        launch(2'd0, 2'b00, 16'd10, 16'd20, 16'd5);
        n_chk++; if (bus.busy !== 1'b1 || bus.ch_active !== 2'b00) $display("FAIL noch_start got busy=%b act=%b want 1/00", bus.busy, bus.ch_active); else n_pass++;
        watch(15, 0, 0);
        n_chk++; if (t_join !== 1 || t_post !== 6) $display("FAIL noch_times got j=%0d p=%0d want 1/6", t_join, t_post); else n_pass++;
        n_chk++; if (n_d0 + n_d1 !== 0 || t_idle !== 6) $display("FAIL noch_end got done=%0d idle=%0d want 0/6", n_d0 + n_d1, t_idle); else n_pass++;
    endtask

    initial begin
        rst_n          = 1'b0;
        bus.start      = 1'b0;
        bus.abort      = 1'b0;
        bus.mode       = 2'd0;
        bus.ch_en      = 2'b00;
        bus.ch_delay   = '0;
        bus.post_delay = '0;
        clear_rec();

        test_reset();
        test_join_all(2'd0, "all");
        test_join_any();
        test_join_none();
        test_simultaneous();
        test_post_with_last();
        test_zero_delay();
        test_start_ignored();
        test_abort();
        test_start_abort_idle();
        test_reset_mid_run();
        test_no_channels();
        test_join_all(2'd3, "mode3");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
